// File: rtl/hbridge_guard.sv
// H-bridge drive guard: shoot-through-safe registered bridge drive with
// dead-time on reversal, overcurrent trip with timed retry, and latched fault.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | bridge off, waiting for a legal nonzero request
// S_DRIVE   | bridge follows the request in the latched direction
// S_DEAD    | reversal dead-time, bridge off
// S_OC_WAIT | cool-down after an overcurrent trip, bridge off
// S_FAULT   | too many trips, bridge off until fault_clr
module hbridge_guard #(
    parameter int          DEADTIME_CYC = 1000,
    parameter logic [15:0] OC_THRESH    = 16'd800,
    parameter int          OC_SAMPLES   = 4,
    parameter int          RETRY_CYC    = 1000000,
    parameter int          MAX_RETRIES  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  in_req,
    input  logic [15:0] current,
    input  logic        current_valid,
    input  logic        fault_clr,
    output logic [3:0]  IN,
    output logic        fault,
    output logic        oc_active,
    output logic        illegal_req
);

    localparam int TMR_MAX = (DEADTIME_CYC > RETRY_CYC) ? DEADTIME_CYC : RETRY_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int OC_W    = $clog2(OC_SAMPLES + 1);
    localparam int RT_W    = $clog2(MAX_RETRIES + 1);

    localparam logic [TMR_W-1:0] DEAD_LOAD  = TMR_W'(DEADTIME_CYC - 1);
    localparam logic [TMR_W-1:0] RETRY_LOAD = TMR_W'(RETRY_CYC - 1);
    localparam logic [OC_W-1:0]  OC_LAST    = OC_W'(OC_SAMPLES - 1);
    localparam logic [RT_W-1:0]  RT_MAX     = RT_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_DEAD,
        S_OC_WAIT,
        S_FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       dir, dir_nxt;
    logic [3:0]       in_nxt;
    logic [TMR_W-1:0] tmr;
    logic [OC_W-1:0]  oc_cnt;
    logic [RT_W-1:0]  retry_cnt;
    logic [RT_W-1:0]  retry_inc;

    logic       req_legal;
    logic [3:0] req_eff;
    logic       oc_over;
    logic       oc_trip;

    assign req_legal = (in_req == 4'b0000) || (in_req == 4'b1001) || (in_req == 4'b0110);
    assign req_eff   = req_legal ? in_req : 4'b0000;
    assign oc_over   = current > OC_THRESH;
    // The sample that brings the run to OC_SAMPLES trips in the same cycle.
    assign oc_trip   = (state == S_DRIVE) && current_valid && oc_over && (oc_cnt == OC_LAST);
    assign retry_inc = retry_cnt + RT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            dir         <= 4'b0000;
            IN          <= 4'b0000;
            illegal_req <= 1'b0;
            tmr         <= '0;
            oc_cnt      <= '0;
            retry_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            dir         <= dir_nxt;
            IN          <= in_nxt;
            illegal_req <= ~req_legal;

            if (state != S_DEAD && state_nxt == S_DEAD)
                tmr <= DEAD_LOAD;
            else if (state != S_OC_WAIT && state_nxt == S_OC_WAIT)
                tmr <= RETRY_LOAD;
            else if ((state == S_DEAD || state == S_OC_WAIT) && tmr != '0)
                tmr <= tmr - TMR_W'(1);

            if (state != S_DRIVE || oc_trip)
                oc_cnt <= '0;
            else if (current_valid)
                oc_cnt <= oc_over ? oc_cnt + OC_W'(1) : '0;

            if (state == S_FAULT && fault_clr)
                retry_cnt <= '0;
            else if (oc_trip)
                retry_cnt <= retry_inc;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        case (state)
            S_IDLE: begin
                if (req_eff != 4'b0000) begin
                    dir_nxt   = req_eff;
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // A trip outranks a simultaneous reversal.
                if (oc_trip)
                    state_nxt = (retry_inc == RT_MAX) ? S_FAULT : S_OC_WAIT;
                else if (req_eff != 4'b0000 && req_eff != dir) begin
                    dir_nxt   = req_eff;
                    state_nxt = S_DEAD;
                end
            end
            S_DEAD: begin
                if (req_eff != 4'b0000)
                    dir_nxt = req_eff;
                if (tmr == '0)
                    state_nxt = S_DRIVE;
            end
            S_OC_WAIT: begin
                if (tmr == '0)
                    state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_nxt    = 4'b0000;
        fault     = (state == S_FAULT);
        oc_active = (state == S_OC_WAIT);
        // req_eff only ever holds 0000/1001/0110, so IN cannot short a leg.
        if (state_nxt == S_DRIVE && req_eff == dir_nxt)
            in_nxt = req_eff;
    end

endmodule

// File: tb/tb_hbridge_guard.sv
// Randomised and directed bench for hbridge_guard with a timestamp-based
// reference model feeding a scoreboard queue drained by a monitor.
module tb_hbridge_guard;

    localparam int          DEADTIME_CYC = 4;
    localparam logic [15:0] OC_THRESH    = 16'd800;
    localparam int          OC_SAMPLES   = 2;
    localparam int          RETRY_CYC    = 8;
    localparam int          MAX_RETRIES  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  in_req = 4'b0000;
    logic [15:0] current = 16'd0;
    logic        current_valid = 1'b0;
    logic        fault_clr = 1'b0;
    logic [3:0]  IN;
    logic        fault;
    logic        oc_active;
    logic        illegal_req;

    always #5 clk = ~clk;

    hbridge_guard #(
        .DEADTIME_CYC (DEADTIME_CYC),
        .OC_THRESH    (OC_THRESH),
        .OC_SAMPLES   (OC_SAMPLES),
        .RETRY_CYC    (RETRY_CYC),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_req        (in_req),
        .current       (current),
        .current_valid (current_valid),
        .fault_clr     (fault_clr),
        .IN            (IN),
        .fault         (fault),
        .oc_active     (oc_active),
        .illegal_req   (illegal_req)
    );

    typedef struct {
        logic [3:0] in_v;
        logic       flt;
        logic       oc;
        logic       ill;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int failures = 0;

    typedef enum int {M_IDLE, M_DRIVE, M_DEAD, M_WAIT, M_FAULT} mmode_t;
    mmode_t     m_mode = M_IDLE;
    logic [3:0] m_dir = 4'b0000;
    int         cyc = 0;
    int         dead_end = 0;
    int         wait_end = 0;
    int         run = 0;
    int         trips = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_dir  = 4'b0000;
        cyc    = 0;
        run    = 0;
        trips  = 0;
    endtask

    // One clock of the behavioural model; pushes the outputs expected after the edge.
    task automatic model_step(input logic [3:0] req, input logic [15:0] cur,
                              input logic cv, input logic clr);
        logic       legal;
        logic [3:0] r;
        exp_t       e;
        legal = (req == 4'h0) || (req == 4'h9) || (req == 4'h6);
        r     = legal ? req : 4'h0;
        case (m_mode)
            M_IDLE: if (r != 4'h0) begin m_dir = r; m_mode = M_DRIVE; end
            M_DRIVE: begin
                if (cv) run = (cur > OC_THRESH) ? run + 1 : 0;
                if (run >= OC_SAMPLES) begin
                    trips++;
                    run      = 0;
                    m_mode   = (trips >= MAX_RETRIES) ? M_FAULT : M_WAIT;
                    wait_end = cyc + RETRY_CYC;
                end else if (r != 4'h0 && r != m_dir) begin
                    m_dir    = r;
                    m_mode   = M_DEAD;
                    dead_end = cyc + DEADTIME_CYC;
                end
            end
            M_DEAD: begin
                if (r != 4'h0) m_dir = r;
                if (cyc == dead_end) m_mode = M_DRIVE;
            end
            M_WAIT: if (cyc == wait_end) m_mode = M_IDLE;
            M_FAULT: if (clr) begin trips = 0; m_mode = M_IDLE; end
            default: m_mode = M_IDLE;
        endcase
        if (m_mode != M_DRIVE) run = 0;
        e.in_v = (m_mode == M_DRIVE && r == m_dir && r != 4'h0) ? r : 4'h0;
        e.flt  = (m_mode == M_FAULT);
        e.oc   = (m_mode == M_WAIT);
        e.ill  = ~legal;
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic drive(input logic [3:0] req, input logic [15:0] cur,
                         input logic cv, input logic clr);
        @(posedge clk);
        #2;
        in_req        = req;
        current       = cur;
        current_valid = cv;
        fault_clr     = clr;
        model_step(req, cur, cv, clr);
    endtask

    task automatic drive_n(input int n, input logic [3:0] req);
        for (int i = 0; i < n; i++) drive(req, 16'd0, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2;
        reset         = 1'b0;
        in_req        = 4'h0;
        current       = 16'd0;
        current_valid = 1'b0;
        fault_clr     = 1'b0;
        #1;
        check({tag, "_IN"}, 32'(IN), 32'h0);
        check({tag, "_fault"}, 32'(fault), 32'h0);
        check({tag, "_oc"}, 32'(oc_active), 32'h0);
        check({tag, "_ill"}, 32'(illegal_req), 32'h0);
        sb_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("IN", 32'(IN), 32'(e.in_v));
                check("fault", 32'(fault), 32'(e.flt));
                check("oc_active", 32'(oc_active), 32'(e.oc));
                check("illegal_req", 32'(illegal_req), 32'(e.ill));
            end
        end
    end

    initial begin : stim
        logic [3:0]  rq;
        logic [15:0] cv_val;
        int          sel;

        #1 reset = 1'b0;
        #1;
        check("por_IN", 32'(IN), 32'h0);
        check("por_fault", 32'(fault), 32'h0);
        check("por_oc", 32'(oc_active), 32'h0);
        check("por_ill", 32'(illegal_req), 32'h0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Forward PWM, no reversal.
        for (int i = 0; i < 6; i++) begin
            drive(4'h9, 16'd0, 1'b0, 1'b0);
            drive(4'h0, 16'd0, 1'b0, 1'b0);
        end
        // Reversal with dead-time.
        drive_n(3, 4'h9);
        drive_n(8, 4'h6);
        // Reversals inside the dead window.
        drive_n(3, 4'h9);
        drive(4'h6, 16'd0, 1'b0, 1'b0);
        drive(4'h9, 16'd0, 1'b0, 1'b0);
        drive_n(6, 4'h6);
        // Illegal (shoot-through) requests.
        drive(4'hC, 16'd0, 1'b0, 1'b0);
        drive_n(3, 4'h6);
        drive_n(2, 4'h3);
        drive_n(2, 4'h6);
        // First overcurrent trip, cool-down, then second trip to fault.
        drive(4'h6, 16'd900, 1'b1, 1'b0);
        drive(4'h6, 16'd900, 1'b1, 1'b0);
        drive_n(11, 4'h0);
        drive_n(2, 4'h9);
        drive(4'h9, 16'd900, 1'b1, 1'b0);
        drive(4'h9, 16'd900, 1'b1, 1'b0);
        drive_n(5, 4'h9);
        drive(4'h0, 16'd0, 1'b0, 1'b1);
        drive_n(2, 4'h0);
        // Counter clear, exact threshold, and sample gaps.
        drive_n(2, 4'h9);
        drive(4'h9, 16'd900, 1'b1, 1'b0);
        drive(4'h9, 16'd500, 1'b1, 1'b0);
        drive(4'h9, 16'd900, 1'b1, 1'b0);
        drive(4'h9, 16'd800, 1'b1, 1'b0);
        drive(4'h9, 16'd900, 1'b1, 1'b0);
        drive(4'h9, 16'd900, 1'b0, 1'b0);
        drive(4'h9, 16'd900, 1'b1, 1'b0);
        drive_n(11, 4'h9);
        // Reset pulsed while driving.
        drive_n(3, 4'h9);
        pulse_reset("rst_mid");
        drive_n(3, 4'h6);

        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: rq = 4'h0;
                3, 4, 5: rq = 4'h9;
                6, 7, 8: rq = 4'h6;
                default: rq = 4'($urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 4))
                0: cv_val = 16'd500;
                1: cv_val = 16'd799;
                2: cv_val = 16'd800;
                3: cv_val = 16'd801;
                default: cv_val = 16'd900;
            endcase
            drive(rq, cv_val, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            if (i == 400) pulse_reset("rst_rand");
        end

        drive_n(1, 4'h0);
        @(posedge clk);
        #3;
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hbridge_guard.md
HBRIDGE_GUARD -- requirements
Module: hbridge_guard

Interface
REQ-001 Parameter DEADTIME_CYC, default 1000, dead-time cycles inserted on a direction reversal (10 us at 100 MHz).
REQ-002 Parameter OC_THRESH, default 16'd800, overcurrent threshold; a sample strictly greater than it is over.
REQ-003 Parameter OC_SAMPLES, default 4, consecutive over samples that trip overcurrent.
REQ-004 Parameter RETRY_CYC, default 1000000, cool-down cycles after an overcurrent trip.
REQ-005 Parameter MAX_RETRIES, default 3, trips allowed before permanent fault.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 in_req  input  4  requested bridge pattern from the PWM motor controller: 1001 forward, 0110 reverse, 0000 coast.
REQ-009 current  input  16  unsigned motor-current ADC sample.
REQ-010 current_valid  input  1  one-cycle strobe qualifying current.
REQ-011 fault_clr  input  1  clears a latched fault; ignored outside FAULT.
REQ-012 IN  output  4  registered, shoot-through-safe bridge drive.
REQ-013 fault  output  1  high while in FAULT.
REQ-014 oc_active  output  1  high while in OC_WAIT.
REQ-015 illegal_req  output  1  one-cycle pulse per cycle in which in_req is illegal.

Function
REQ-016 Legal in_req values SHALL be 0000, 1001 and 0110; any other value SHALL be treated as 0000 and SHALL assert illegal_req on the next cycle.
REQ-017 States SHALL be IDLE, DRIVE, DEAD, OC_WAIT and FAULT; IN SHALL be 0000 in every state except DRIVE.
REQ-018 IDLE: a legal nonzero in_req SHALL latch dir and move to DRIVE.
REQ-019 DRIVE: IN SHALL equal in_req when in_req equals dir, and 0000 when in_req is 0000.
REQ-020 DRIVE output latency SHALL be exactly one cycle from in_req to IN.
REQ-021 DRIVE: a 0000 in_req (PWM off phase) SHALL NOT clear dir or change state.
REQ-022 DRIVE: a legal nonzero in_req differing from dir SHALL latch the new dir and move to DEAD, driving IN 0000 on the next cycle.
REQ-023 DEAD SHALL hold for exactly DEADTIME_CYC cycles, then return to DRIVE.
REQ-024 A further reversal request during DEAD SHALL update dir and SHALL NOT restart the dead-time counter.
REQ-025 The overcurrent counter SHALL count only in DRIVE:
- a current_valid sample over OC_THRESH increments it;
- a valid sample not over the threshold clears it;
- a cycle without current_valid leaves it unchanged;
- it is cleared in every other state.
REQ-026 When the counter reaches OC_SAMPLES, the block SHALL increment retry_cnt and enter FAULT if retry_cnt now equals MAX_RETRIES, otherwise enter OC_WAIT; IN SHALL be 0000 from the next cycle.
REQ-027 OC_WAIT SHALL last RETRY_CYC cycles, then go to IDLE.
REQ-028 FAULT SHALL persist until fault_clr, which SHALL clear retry_cnt and go to IDLE.
REQ-029 An overcurrent trip and a reversal in the same cycle SHALL resolve as the trip.
REQ-030 The counter widths SHALL be set from the parameter values, and the counters SHALL NOT wrap.
REQ-031 IN SHALL never show 11xx or xx11.

Reset
REQ-032 While reset is low:
- state = IDLE, dir = 0000, IN = 0000;
- fault, oc_active and illegal_req = 0;
- all counters and retry_cnt = 0.
REQ-033 Reset assertion mid-DRIVE SHALL force IN to 0000 asynchronously, without waiting for a clock edge.

Verification (bench uses DEADTIME_CYC=4, OC_SAMPLES=2, RETRY_CYC=8, MAX_RETRIES=2)
REQ-034 Forward PWM: in_req alternates 1001 and 0000 -> IN follows one cycle late, with no DEAD entry.
REQ-035 Reversal: 1001 steady, then 0110 -> IN = 0000 for 4 cycles, then 0110.
REQ-036 Shoot-through input: in_req = 1100 -> IN = 0000 and illegal_req pulses for one cycle.
REQ-037 Overcurrent retry:
- 2 valid samples of 900 -> IN = 0000 and oc_active high for 8 cycles, then IDLE;
- a second trip -> fault = 1;
- fault_clr -> IDLE with fault = 0.
REQ-038 Counter clear and reset: samples 900, 500, 900 -> no trip; reset pulsed low mid-DRIVE -> IN = 0000 immediately, all outputs at their reset values.
